// File: rtl/ball_motion.sv
// ball_motion: per-frame ball kinematics, serve/score state machine and scores for VGA air-hockey.
// Optional feature: define BALL_MOTION_SPEEDUP_EN to speed the ball up on each reversing paddle hit.
module ball_motion #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_W       = 16,
    parameter int BALL_H       = 16,
    parameter int START_SPEED  = 2,
    parameter int MAX_SPEED    = 8,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        pixelClock,
    input  logic        resetN,
    input  logic        vSyncStart,
    input  logic        collisionBallScreenLeft,
    input  logic        collisionBallScreenRight,
    input  logic        collisionBallScreenTop,
    input  logic        collisionBallScreenBottom,
    input  logic        collisionBallPlayerPaddle,
    input  logic        collisionBallComputerPaddle,
    output logic [15:0] ballX,
    output logic [15:0] ballY,
    output logic [7:0]  ballXSpeed,
    output logic [7:0]  ballYSpeed,
    output logic        ballDirX,
    output logic        ballDirY,
    output logic [3:0]  playerScore,
    output logic [3:0]  computerScore,
    output logic        playerPoint,
    output logic        computerPoint,
    output logic        inPlay
);

    localparam logic [15:0] MAX_X       = 16'(SCREEN_W - BALL_W);
    localparam logic [15:0] MAX_Y       = 16'(SCREEN_H - BALL_H);
    localparam logic [15:0] CENTRE_X    = 16'((SCREEN_W - BALL_W) / 2);
    localparam logic [15:0] CENTRE_Y    = 16'((SCREEN_H - BALL_H) / 2);
    localparam logic [15:0] SERVE_LAST  = 16'(SERVE_FRAMES - 1);
    localparam logic [7:0]  START_SPD   = 8'(START_SPEED);
    localparam logic [7:0]  MAX_SPD     = 8'(MAX_SPEED);
    // Serve never launches faster than the X ceiling.
    localparam logic [7:0]  SERVE_X_SPD = (START_SPD > MAX_SPD) ? MAX_SPD : START_SPD;
    localparam logic [3:0]  SCORE_MAX   = 4'd9;

    typedef enum logic [1:0] {
        SERVE  = 2'd0,
        PLAY   = 2'd1,
        SCORED = 2'd2
    } state_t;

    state_t      state_r;
    logic        frameTick_r;
    logic [15:0] serveCnt_r;
    logic        serveDir_r;
    logic        playerScored_r;

    logic        bounceDirX_s;
    logic        bounceDirY_s;
    logic [7:0]  nextXSpeed_s;
    logic [16:0] sumX_s;
    logic [16:0] sumY_s;
    logic [15:0] nextX_s;
    logic [15:0] nextY_s;

    // Frame tick: vSyncStart delayed one cycle so upstream collision flags have settled.
    always_ff @(posedge pixelClock) begin
        if (!resetN) begin
            frameTick_r <= 1'b0;
        end else begin
            frameTick_r <= vSyncStart;
        end
    end

    // Bounce resolution and clamped next position for a PLAY frame.
    always_comb begin
        bounceDirX_s = ballDirX;
        bounceDirY_s = ballDirY;
        nextXSpeed_s = ballXSpeed;
        nextX_s      = ballX;
        nextY_s      = ballY;

        if (collisionBallScreenTop) begin
            bounceDirY_s = 1'b1;
        end else if (collisionBallScreenBottom) begin
            bounceDirY_s = 1'b0;
        end else begin
            bounceDirY_s = ballDirY;
        end

        if (collisionBallPlayerPaddle) begin
            bounceDirX_s = 1'b1;
        end else if (collisionBallComputerPaddle) begin
            bounceDirX_s = 1'b0;
        end else begin
            bounceDirX_s = ballDirX;
        end

`ifdef BALL_MOTION_SPEEDUP_EN
        if ((bounceDirX_s != ballDirX) && (ballXSpeed < MAX_SPD)) begin
            nextXSpeed_s = ballXSpeed + 8'd1;
        end else begin
            nextXSpeed_s = ballXSpeed;
        end
`else
        nextXSpeed_s = ballXSpeed;
`endif

        // 17-bit sums so a move near the far edge cannot wrap before the clamp.
        sumX_s = {1'b0, ballX} + {9'd0, nextXSpeed_s};
        sumY_s = {1'b0, ballY} + {9'd0, ballYSpeed};

        if (bounceDirX_s) begin
            nextX_s = (sumX_s > {1'b0, MAX_X}) ? MAX_X : sumX_s[15:0];
        end else begin
            nextX_s = (ballX < {8'd0, nextXSpeed_s}) ? 16'd0 : (ballX - {8'd0, nextXSpeed_s});
        end

        if (bounceDirY_s) begin
            nextY_s = (sumY_s > {1'b0, MAX_Y}) ? MAX_Y : sumY_s[15:0];
        end else begin
            nextY_s = (ballY < {8'd0, ballYSpeed}) ? 16'd0 : (ballY - {8'd0, ballYSpeed});
        end
    end

    // Serve/play/scored state machine with registered ball and score outputs.
    always_ff @(posedge pixelClock) begin
        if (!resetN) begin
            state_r        <= SERVE;
            serveCnt_r     <= 16'd0;
            serveDir_r     <= 1'b0;
            playerScored_r <= 1'b0;
            ballX          <= CENTRE_X;
            ballY          <= CENTRE_Y;
            ballXSpeed     <= 8'd0;
            ballYSpeed     <= 8'd0;
            ballDirX       <= 1'b0;
            ballDirY       <= 1'b1;
            playerScore    <= 4'd0;
            computerScore  <= 4'd0;
            playerPoint    <= 1'b0;
            computerPoint  <= 1'b0;
            inPlay         <= 1'b0;
        end else begin
            playerPoint   <= 1'b0;
            computerPoint <= 1'b0;
            if (frameTick_r) begin
                case (state_r)
                    SERVE: begin
                        ballX <= CENTRE_X;
                        ballY <= CENTRE_Y;
                        if (serveCnt_r == SERVE_LAST) begin
                            state_r    <= PLAY;
                            serveCnt_r <= 16'd0;
                            ballXSpeed <= SERVE_X_SPD;
                            ballYSpeed <= START_SPD;
                            ballDirX   <= serveDir_r;
                            ballDirY   <= 1'b1;
                            serveDir_r <= ~serveDir_r;
                            inPlay     <= 1'b1;
                        end else begin
                            serveCnt_r <= serveCnt_r + 16'd1;
                        end
                    end
                    PLAY: begin
                        if (collisionBallScreenLeft) begin
                            state_r        <= SCORED;
                            playerScored_r <= 1'b0;
                            inPlay         <= 1'b0;
                        end else if (collisionBallScreenRight) begin
                            state_r        <= SCORED;
                            playerScored_r <= 1'b1;
                            inPlay         <= 1'b0;
                        end else begin
                            ballDirX   <= bounceDirX_s;
                            ballDirY   <= bounceDirY_s;
                            ballXSpeed <= nextXSpeed_s;
                            ballX      <= nextX_s;
                            ballY      <= nextY_s;
                        end
                    end
                    SCORED: begin
                        if (playerScored_r) begin
                            playerPoint <= 1'b1;
                            if (playerScore != SCORE_MAX) begin
                                playerScore <= playerScore + 4'd1;
                            end
                        end else begin
                            computerPoint <= 1'b1;
                            if (computerScore != SCORE_MAX) begin
                                computerScore <= computerScore + 4'd1;
                            end
                        end
                        ballX   <= CENTRE_X;
                        ballY   <= CENTRE_Y;
                        state_r <= SERVE;
                    end
                    default: begin
                        state_r <= SERVE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: rally vector table, scoreboarded frames, serve/clamp/score sequences.
module tb_ball_motion;

`ifdef BALL_MOTION_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    // Odd ball size keeps the centre at (312,232) but makes the far walls odd (625,465).
    localparam int MAXX = 625;
    localparam int MAXY = 465;
    localparam int SFRAMES = 60;

    localparam logic [5:0] F_L = 6'b100000;
    localparam logic [5:0] F_R = 6'b010000;
    localparam logic [5:0] F_T = 6'b001000;
    localparam logic [5:0] F_B = 6'b000100;
    localparam logic [5:0] F_P = 6'b000010;
    localparam logic [5:0] F_C = 6'b000001;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  xs;
        logic [7:0]  ys;
        logic        dx;
        logic        dy;
        logic [3:0]  ps;
        logic [3:0]  cs;
        logic        pp;
        logic        cp;
        logic        ip;
    } outs_t;

    typedef struct {
        logic [5:0] flags;
        outs_t      exp;
    } vec_t;

    logic        pixelClock = 1'b0;
    logic        resetN     = 1'b0;
    logic        vSyncStart = 1'b0;
    logic [5:0]  flags      = 6'd0;
    logic [15:0] ballX, ballY;
    logic [7:0]  ballXSpeed, ballYSpeed;
    logic        ballDirX, ballDirY;
    logic [3:0]  playerScore, computerScore;
    logic        playerPoint, computerPoint, inPlay;

    int    nChecks = 0;
    int    nErrors = 0;
    outs_t exp;
    outs_t resetVals;
    outs_t sbq[$];
    logic  sdir;
    vec_t  vecs[6];

    ball_motion #(
        .BALL_W(15),
        .BALL_H(15)
    ) dut (
        .pixelClock                 (pixelClock),
        .resetN                     (resetN),
        .vSyncStart                 (vSyncStart),
        .collisionBallScreenLeft    (flags[5]),
        .collisionBallScreenRight   (flags[4]),
        .collisionBallScreenTop     (flags[3]),
        .collisionBallScreenBottom  (flags[2]),
        .collisionBallPlayerPaddle  (flags[1]),
        .collisionBallComputerPaddle(flags[0]),
        .ballX                      (ballX),
        .ballY                      (ballY),
        .ballXSpeed                 (ballXSpeed),
        .ballYSpeed                 (ballYSpeed),
        .ballDirX                   (ballDirX),
        .ballDirY                   (ballDirY),
        .playerScore                (playerScore),
        .computerScore              (computerScore),
        .playerPoint                (playerPoint),
        .computerPoint              (computerPoint),
        .inPlay                     (inPlay)
    );

    always #5 pixelClock = ~pixelClock;

    function automatic outs_t sampleDut();
        outs_t o;
        o = '{x: ballX, y: ballY, xs: ballXSpeed, ys: ballYSpeed, dx: ballDirX, dy: ballDirY,
              ps: playerScore, cs: computerScore, pp: playerPoint, cp: computerPoint, ip: inPlay};
        return o;
    endfunction

    function automatic string fmt(outs_t o);
        return $sformatf("x=%0d y=%0d xs=%0d ys=%0d dx=%0b dy=%0b ps=%0d cs=%0d pp=%0b cp=%0b ip=%0b",
                         o.x, o.y, o.xs, o.ys, o.dx, o.dy, o.ps, o.cs, o.pp, o.cp, o.ip);
    endfunction

    function automatic vec_t mk(logic [5:0] f, int x, int y, int xs, logic dx, logic dy,
                                int cs, logic cp, logic ip);
        vec_t v;
        v.flags = f;
        v.exp   = '{x: 16'(x), y: 16'(y), xs: 8'(xs), ys: 8'd2, dx: dx, dy: dy,
                    ps: 4'd0, cs: 4'(cs), pp: 1'b0, cp: cp, ip: ip};
        return v;
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t want);
        nChecks++;
        if (got !== want) begin
            nErrors++;
            $display("FAIL %s: got %s, expected %s", name, fmt(got), fmt(want));
        end
    endtask

    // One frame: push the expectation, strobe vSyncStart, compare 2 cycles later, then check it holds.
    task automatic runFrame(input string name, input logic [5:0] f, input outs_t want);
        outs_t got;
        outs_t front;
        outs_t held;
        sbq.push_back(want);
        flags      = f;
        vSyncStart = 1'b1;
        @(posedge pixelClock);
        #1 vSyncStart = 1'b0;
        @(posedge pixelClock);
        #1 got = sampleDut();
        flags = 6'd0;
        if (sbq.size() == 0) begin
            nChecks++;
            nErrors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            front = sbq.pop_front();
            check(name, got, front);
            held    = front;
            held.pp = 1'b0;
            held.cp = 1'b0;
            @(posedge pixelClock);
            #1 check({name, "_hold"}, sampleDut(), held);
        end
        @(posedge pixelClock);
        #1;
    endtask

    // Reference step for a PLAY frame with no goal flag.
    task automatic modelStep(input logic [5:0] f);
        bit rev;
        int nx;
        int ny;
        rev = 1'b0;
        if (f[3]) exp.dy = 1'b1;
        else if (f[2]) exp.dy = 1'b0;
        if (f[1]) begin
            rev    = (exp.dx == 1'b0);
            exp.dx = 1'b1;
        end else if (f[0]) begin
            rev    = (exp.dx == 1'b1);
            exp.dx = 1'b0;
        end
        if (SPEEDUP && rev && exp.xs < 8) exp.xs = exp.xs + 8'd1;
        nx = exp.dx ? int'(exp.x) + int'(exp.xs) : int'(exp.x) - int'(exp.xs);
        ny = exp.dy ? int'(exp.y) + int'(exp.ys) : int'(exp.y) - int'(exp.ys);
        if (nx > MAXX) nx = MAXX;
        if (nx < 0) nx = 0;
        if (ny > MAXY) ny = MAXY;
        if (ny < 0) ny = 0;
        exp.x = 16'(nx);
        exp.y = 16'(ny);
    endtask

    task automatic doServe();
        exp.x  = 16'd312;
        exp.y  = 16'd232;
        exp.ip = 1'b0;
        for (int i = 0; i < SFRAMES - 1; i++) begin
            runFrame("serveHold", (i % 7 == 3) ? 6'($urandom_range(63, 0)) : 6'd0, exp);
        end
        exp.xs = 8'd2;
        exp.ys = 8'd2;
        exp.dx = sdir;
        exp.dy = 1'b1;
        exp.ip = 1'b1;
        runFrame("launch", 6'd0, exp);
        sdir = ~sdir;
    endtask

    task automatic scoreGoal(input string name, input logic [5:0] f, input logic player);
        exp.ip = 1'b0;
        runFrame(name, f, exp);
        if (player) begin
            exp.ps = (exp.ps == 4'd9) ? 4'd9 : exp.ps + 4'd1;
            exp.pp = 1'b1;
        end else begin
            exp.cs = (exp.cs == 4'd9) ? 4'd9 : exp.cs + 4'd1;
            exp.cp = 1'b1;
        end
        exp.x = 16'd312;
        exp.y = 16'd232;
        runFrame({name, "_scored"}, 6'd0, exp);
        exp.pp = 1'b0;
        exp.cp = 1'b0;
    endtask

    initial begin
        logic [5:0] spdSeq [8];
        resetVals = '{x: 16'd312, y: 16'd232, xs: 8'd0, ys: 8'd0, dx: 1'b0, dy: 1'b1,
                      ps: 4'd0, cs: 4'd0, pp: 1'b0, cp: 1'b0, ip: 1'b0};
        vecs[0] = mk(6'd0,      310, 234, 2,                 1'b0, 1'b1, 0, 1'b0, 1'b1);
        vecs[1] = mk(F_T | F_P, SPEEDUP ? 313 : 312, 236, SPEEDUP ? 3 : 2, 1'b1, 1'b1, 0, 1'b0, 1'b1);
        vecs[2] = mk(F_B,       SPEEDUP ? 316 : 314, 234, SPEEDUP ? 3 : 2, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        vecs[3] = mk(F_C,       312, 232, SPEEDUP ? 4 : 2,   1'b0, 1'b0, 0, 1'b0, 1'b1);
        vecs[4] = mk(F_L | F_P, 312, 232, SPEEDUP ? 4 : 2,   1'b0, 1'b0, 0, 1'b0, 1'b0);
        vecs[5] = mk(6'd0,      312, 232, SPEEDUP ? 4 : 2,   1'b0, 1'b0, 1, 1'b1, 1'b0);
        spdSeq  = '{F_P, F_C, F_P, F_C, F_P, F_C, F_P, F_P};
        sdir    = 1'b0;

        // Reset with a frame strobe held high; it must be discarded.
        resetN     = 1'b0;
        vSyncStart = 1'b1;
        repeat (3) @(posedge pixelClock);
        #1 check("reset", sampleDut(), resetVals);
        resetN     = 1'b1;
        vSyncStart = 1'b0;
        @(posedge pixelClock);
        #1 check("resetRelease", sampleDut(), resetVals);

        exp = resetVals;
        doServe();

        for (int i = 0; i < 6; i++) begin
            exp.pp = 1'b0;
            runFrame($sformatf("rally%0d", i), vecs[i].flags, vecs[i].exp);
            exp = vecs[i].exp;
        end
        exp.pp = 1'b0;
        exp.cp = 1'b0;

        // Clamp: run right/down into both far walls, then back left/up to zero.
        doServe();
        for (int i = 0; i < 400 && exp.x != 16'(MAXX); i++) begin
            modelStep(6'd0);
            runFrame("clampRight", 6'd0, exp);
        end
        modelStep(F_C | F_B);
        runFrame("bounceCB", F_C | F_B, exp);
        for (int i = 0; i < 400 && exp.x != 16'd0; i++) begin
            modelStep(6'd0);
            runFrame("clampLeft", 6'd0, exp);
        end
        scoreGoal("leftGoal", F_L, 1'b0);

        // Alternating paddle hits, then a repeated same-side hit.
        doServe();
        for (int i = 0; i < 8; i++) begin
            modelStep(spdSeq[i]);
            runFrame("speedUp", spdSeq[i], exp);
        end
        scoreGoal("goalPriority", F_R | F_C, 1'b1);

        for (int k = 0; k < 9; k++) begin
            doServe();
            scoreGoal("playerGoal", F_R, 1'b1);
        end
        nChecks++;
        if (playerScore !== 4'd9) begin
            nErrors++;
            $display("FAIL scoreSat: got %0d, expected 9", playerScore);
        end

        // Mid-rally reset with a simultaneous frame strobe.
        doServe();
        modelStep(6'd0);
        runFrame("preReset", 6'd0, exp);
        resetN     = 1'b0;
        vSyncStart = 1'b1;
        @(posedge pixelClock);
        #1 check("midReset", sampleDut(), resetVals);
        resetN     = 1'b1;
        vSyncStart = 1'b0;
        @(posedge pixelClock);
        #1 check("postReset", sampleDut(), resetVals);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
